// File: rtl/cgra_output_stream_writer.sv
// CGRA output-node stream to AXI-Lite write master: buffers words in a small FIFO and
// writes them to consecutive 32-bit locations. Define CGRA_OUT_BRESP_ERR_EN for B-error reporting.
module cgra_output_stream_writer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int SIZE_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [ADDR_WIDTH-1:0]   base_addr_i,
  input  logic [SIZE_WIDTH-1:0]   size_i,
  output logic                    busy_o,
  output logic                    done_o,
  input  logic [DATA_WIDTH-1:0]   data_i,
  input  logic                    data_valid_i,
  output logic                    data_ready_o,
  output logic [ADDR_WIDTH-1:0]   awaddr_o,
  output logic [2:0]              awprot_o,
  output logic                    awvalid_o,
  input  logic                    awready_i,
  output logic [DATA_WIDTH-1:0]   wdata_o,
  output logic [DATA_WIDTH/8-1:0] wstrb_o,
  output logic                    wvalid_o,
  input  logic                    wready_i,
  input  logic [1:0]              bresp_i,
  input  logic                    bvalid_i,
  output logic                    bready_o
`ifdef CGRA_OUT_BRESP_ERR_EN
  ,
  output logic                    err_o,
  output logic [7:0]              err_count_o
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, FIN} ctrl_e;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} wr_e;

  ctrl_e                 ctrl_q, ctrl_d;
  wr_e                   wst_q, wst_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [SIZE_WIDTH-1:0] size_q, size_d;
  logic [SIZE_WIDTH-1:0] acc_q, acc_d;
  logic [SIZE_WIDTH-1:0] iss_q, iss_d;
  logic [SIZE_WIDTH-1:0] cmp_q, cmp_d;
  logic                  aw_pend_q, aw_pend_d;
  logic                  w_pend_q, w_pend_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic clear, push, pop, b_hs, fifo_full, fifo_empty;

  assign fifo_full    = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty   = (cnt_q == '0);
  assign data_ready_o = (ctrl_q == RUN) && !fifo_full && (acc_q < size_q);
  assign push         = data_valid_i && data_ready_o;

  assign busy_o    = (ctrl_q == RUN);
  assign done_o    = (ctrl_q == FIN);
  assign awvalid_o = aw_pend_q;
  assign wvalid_o  = w_pend_q;
  assign awprot_o  = 3'b000;
  assign wstrb_o   = '1;
  // Address and data are held at zero while idle so nothing stale leaks out of the buffer.
  assign awaddr_o  = aw_pend_q ? base_q + (ADDR_WIDTH'(iss_q) << 2) : '0;
  assign wdata_o   = w_pend_q ? mem_q[rd_ptr_q] : '0;

  // Control FSM: owns configuration and the transfer lifetime.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    ctrl_d = ctrl_q;
    base_d = base_q;
    size_d = size_q;
    clear  = 1'b0;
    unique case (ctrl_q)
      IDLE: begin
        if (start_i) begin
          base_d = base_addr_i;
          size_d = size_i;
          clear  = 1'b1;
          ctrl_d = (size_i == '0) ? FIN : RUN;
        end
      end
      RUN:     if (cmp_q == size_q) ctrl_d = FIN;
      FIN:     ctrl_d = IDLE;
      default: ctrl_d = IDLE;
    endcase
  end

  // Write engine: a single outstanding AW/W pair, each valid dropping after its own handshake.
  always_comb begin
    wst_d     = wst_q;
    aw_pend_d = aw_pend_q;
    w_pend_d  = w_pend_q;
    pop       = 1'b0;
    b_hs      = 1'b0;
    bready_o  = 1'b0;
    unique case (wst_q)
      W_IDLE: begin
        if ((ctrl_q == RUN) && !fifo_empty) begin
          aw_pend_d = 1'b1;
          w_pend_d  = 1'b1;
          wst_d     = W_REQ;
        end
      end
      W_REQ: begin
        if (aw_pend_q && awready_i) aw_pend_d = 1'b0;
        if (w_pend_q && wready_i)   w_pend_d  = 1'b0;
        if ((!aw_pend_q || awready_i) && (!w_pend_q || wready_i)) begin
          pop   = 1'b1;
          wst_d = W_RESP;
        end
      end
      W_RESP: begin
        bready_o = 1'b1;
        if (bvalid_i) begin
          b_hs  = 1'b1;
          wst_d = W_IDLE;
        end
      end
      default: wst_d = W_IDLE;
    endcase
  end

  always_comb begin
    acc_d    = clear ? '0 : acc_q + SIZE_WIDTH'(push);
    iss_d    = clear ? '0 : iss_q + SIZE_WIDTH'(pop);
    cmp_d    = clear ? '0 : cmp_q + SIZE_WIDTH'(b_hs);
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      ctrl_q    <= IDLE;
      wst_q     <= W_IDLE;
      base_q    <= '0;
      size_q    <= '0;
      acc_q     <= '0;
      iss_q     <= '0;
      cmp_q     <= '0;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      wst_q     <= wst_d;
      base_q    <= base_d;
      size_q    <= size_d;
      acc_q     <= acc_d;
      iss_q     <= iss_d;
      cmp_q     <= cmp_d;
      aw_pend_q <= aw_pend_d;
      w_pend_q  <= w_pend_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  // NOTE: FIFO storage has no reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= data_i;
  end

`ifdef CGRA_OUT_BRESP_ERR_EN
  logic       err_q, err_d;
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    if (clear) begin
      err_d     = 1'b0;
      err_cnt_d = '0;
    end else if (b_hs && (bresp_i != 2'b00)) begin
      err_d = 1'b1;
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_o       = err_q;
  assign err_count_o = err_cnt_q;
`else
  logic bresp_unused;
  assign bresp_unused = ^bresp_i;
`endif

endmodule

// File: tb/tb_cgra_output_stream_writer.sv
// Randomized scoreboard bench for cgra_output_stream_writer; stimulus pushes expected AW/W
// beats, an independent monitor pops and compares on every AXI handshake.
module tb_cgra_output_stream_writer;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [31:0] base_addr_i = '0;
  logic [15:0] size_i = '0;
  logic        busy_o, done_o;
  logic [31:0] data_i = '0;
  logic        data_valid_i = 1'b0;
  logic        data_ready_o;
  logic [31:0] awaddr_o;
  logic [2:0]  awprot_o;
  logic        awvalid_o;
  logic        awready_i = 1'b0;
  logic [31:0] wdata_o;
  logic [3:0]  wstrb_o;
  logic        wvalid_o;
  logic        wready_i = 1'b0;
  logic [1:0]  bresp_i = 2'b00;
  logic        bvalid_i = 1'b0;
  logic        bready_o;
`ifdef CGRA_OUT_BRESP_ERR_EN
  logic        err_o;
  logic [7:0]  err_count_o;
`endif

  cgra_output_stream_writer dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .base_addr_i(base_addr_i),
    .size_i(size_i), .busy_o(busy_o), .done_o(done_o), .data_i(data_i),
    .data_valid_i(data_valid_i), .data_ready_o(data_ready_o), .awaddr_o(awaddr_o),
    .awprot_o(awprot_o), .awvalid_o(awvalid_o), .awready_i(awready_i), .wdata_o(wdata_o),
    .wstrb_o(wstrb_o), .wvalid_o(wvalid_o), .wready_i(wready_i), .bresp_i(bresp_i),
    .bvalid_i(bvalid_i), .bready_o(bready_o)
`ifdef CGRA_OUT_BRESP_ERR_EN
    , .err_o(err_o), .err_count_o(err_count_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard and monitor counters.
  logic [31:0] exp_aw[$];
  logic [31:0] exp_w[$];
  int acc_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0, done_cnt = 0, awv_cycles = 0, berr_cnt = 0;
  int acc_base = 0, cur_size = 0;

  // Slave knobs.
  int aw_prob = 100, w_prob = 100, b_prob = 100;
  int dly_mode = 0, aw_dly = 0, w_dly = 0, aw_hold = 0;
  int err_idx = -1, b_base = 0, b_asserted = 0;
  int aw_age = 0, w_age = 0;

  // Monitor: samples on the falling edge, counting handshakes that complete on the next rising edge.
  initial begin
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        acc_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0; done_cnt = 0; awv_cycles = 0; berr_cnt = 0;
        exp_aw.delete();
        exp_w.delete();
      end else begin
        if (data_valid_i && data_ready_o) begin
          check("accept_within_size", 32'((acc_cnt - acc_base) < cur_size), 32'd1);
          acc_cnt++;
        end
        if (awvalid_o) awv_cycles++;
        if (awvalid_o && awready_i) begin
          if (exp_aw.size() == 0) check("aw_unexpected", 32'(aw_cnt + 1), 32'(aw_cnt));
          else check("aw_addr", awaddr_o, exp_aw.pop_front());
          check("awprot", 32'(awprot_o), 32'd0);
          aw_cnt++;
        end
        if (wvalid_o && wready_i) begin
          if (exp_w.size() == 0) check("w_unexpected", 32'(w_cnt + 1), 32'(w_cnt));
          else check("wdata", wdata_o, exp_w.pop_front());
          check("wstrb", 32'(wstrb_o), 32'hF);
          w_cnt++;
        end
        if (bvalid_i && bready_o) begin
          b_cnt++;
          if (bresp_i != 2'b00) berr_cnt++;
        end
        if (done_o) done_cnt++;
      end
    end
  end

  // AXI-Lite slave: drives ready/response inputs just after each rising edge.
  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      if (rst_i) begin
        awready_i = 1'b0; wready_i = 1'b0; bvalid_i = 1'b0;
        b_asserted = 0; aw_age = 0; w_age = 0;
        continue;
      end
      aw_age = awvalid_o ? aw_age + 1 : 0;
      w_age  = wvalid_o ? w_age + 1 : 0;
      if (aw_hold > 0) begin
        aw_hold--;
        awready_i = 1'b0;
      end else if (dly_mode != 0) awready_i = awvalid_o && (aw_age > aw_dly);
      else awready_i = ($urandom_range(0, 99) < aw_prob);
      if (dly_mode != 0) wready_i = wvalid_o && (w_age > w_dly);
      else wready_i = ($urandom_range(0, 99) < w_prob);
      if (bvalid_i && (b_cnt == b_asserted)) bvalid_i = 1'b0;
      if (!bvalid_i && (((aw_cnt < w_cnt) ? aw_cnt : w_cnt) > b_asserted) &&
          ($urandom_range(0, 99) < b_prob)) begin
`ifdef CGRA_OUT_BRESP_ERR_EN
        bresp_i = ((err_idx == -2) || ((b_asserted - b_base) == err_idx)) ? 2'b10 : 2'b00;
`else
        bresp_i = 2'($urandom);
`endif
        bvalid_i = 1'b1;
        b_asserted++;
      end
    end
  end

  task automatic run_transfer(input logic [31:0] base, input int size, input int vprob,
                              input bit fixed_words, input bit stall_chk, input bit mid_start);
    logic [31:0] words[$];
    int acc0, aw0, w0, done0, awv0, berr0, idx, cyc;
    for (int i = 0; i < size; i++) begin
      logic [31:0] w;
      w = fixed_words ? 32'(i + 1) * 32'h11 : $urandom;
      words.push_back(w);
      exp_aw.push_back(base + 32'(4 * i));
      exp_w.push_back(w);
    end
    @(posedge clk_i);
    #1;
    acc0 = acc_cnt; aw0 = aw_cnt; w0 = w_cnt; done0 = done_cnt; awv0 = awv_cycles; berr0 = berr_cnt;
    acc_base = acc_cnt; cur_size = size; b_base = b_asserted;
    start_i = 1'b1; base_addr_i = base; size_i = 16'(size);
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    cyc = 0;
    while ((cyc < 4000) && (done_cnt == done0)) begin
      idx = acc_cnt - acc_base;
      if (idx < size) begin
        data_valid_i = ($urandom_range(0, 99) < vprob);
        data_i = words[idx];
      end else begin
        data_valid_i = 1'b1;
        data_i = $urandom;
      end
      if (mid_start && (cyc == 3)) begin
        start_i = 1'b1; base_addr_i = ~base; size_i = 16'd7;
      end else start_i = 1'b0;
      if (stall_chk && (cyc == 15)) begin
        check("stall_accepted", 32'(acc_cnt - acc0), 32'd4);
        check("stall_ready_low", 32'(data_ready_o), 32'd0);
      end
      @(posedge clk_i);
      #1;
      cyc++;
    end
    data_valid_i = 1'b0;
    start_i = 1'b0;
    check("done_seen", 32'(done_cnt - done0), 32'd1);
    check("busy_after_done", 32'(busy_o), 32'd0);
    if (size == 0) begin
      check("size0_done_latency", 32'(cyc), 32'd1);
      check("size0_no_aw", 32'(awv_cycles - awv0), 32'd0);
    end
    repeat (3) @(posedge clk_i);
    #1;
    check("single_done", 32'(done_cnt - done0), 32'd1);
    check("accepted_count", 32'(acc_cnt - acc0), 32'(size));
    check("aw_count", 32'(aw_cnt - aw0), 32'(size));
    check("w_count", 32'(w_cnt - w0), 32'(size));
    check("aw_left", 32'(exp_aw.size()), 32'd0);
    check("w_left", 32'(exp_w.size()), 32'd0);
`ifdef CGRA_OUT_BRESP_ERR_EN
    check("err_count", 32'(err_count_o), ((berr_cnt - berr0) > 255) ? 32'd255 : 32'(berr_cnt - berr0));
    check("err_flag", 32'(err_o), 32'((berr_cnt - berr0) > 0));
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset values.
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_ready", 32'(data_ready_o), 32'd0);
    check("rst_awvalid", 32'(awvalid_o), 32'd0);
    check("rst_wvalid", 32'(wvalid_o), 32'd0);
    check("rst_bready", 32'(bready_o), 32'd0);
    check("rst_awaddr", awaddr_o, 32'd0);
    check("rst_wdata", wdata_o, 32'd0);
    check("rst_wstrb", 32'(wstrb_o), 32'hF);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Basic ordered transfer with an always-ready slave.
    run_transfer(32'h9000_0050, 4, 100, 1'b1, 1'b0, 1'b0);

    // Back-pressure: AW stalled while the FIFO fills.
    aw_hold = 20;
    run_transfer($urandom & 32'hFFFF_FFFC, 8, 100, 1'b0, 1'b1, 1'b0);

    // AW late, W late, then both together.
    dly_mode = 1; aw_dly = 3; w_dly = 0;
    run_transfer(32'h0000_1000, 3, 100, 1'b0, 1'b0, 1'b0);
    aw_dly = 0; w_dly = 3;
    run_transfer(32'h0000_2000, 3, 100, 1'b0, 1'b0, 1'b0);
    aw_dly = 0; w_dly = 0;
    run_transfer(32'h0000_3000, 3, 100, 1'b0, 1'b0, 1'b0);
    dly_mode = 0;

    // Empty transfer, then a start pulse that must be ignored mid-transfer.
    run_transfer(32'h4000_0000, 0, 100, 1'b0, 1'b0, 1'b0);
    run_transfer(32'h5000_0100, 4, 100, 1'b0, 1'b0, 1'b1);

    // Address wrap at the top of the address space.
    run_transfer(32'hFFFF_FFF8, 5, 80, 1'b0, 1'b0, 1'b0);

    // Randomized transfers.
    for (int r = 0; r < 6; r++) begin
      aw_prob = $urandom_range(30, 100);
      w_prob  = $urandom_range(30, 100);
      b_prob  = $urandom_range(30, 100);
      run_transfer($urandom & 32'hFFFF_FFFC, $urandom_range(1, 12), $urandom_range(30, 100),
                   1'b0, 1'b0, 1'b0);
    end
    aw_prob = 100; w_prob = 100; b_prob = 100;

    // Asynchronous reset in W_REQ with two words buffered.
    aw_prob = 0; w_prob = 0;
    @(posedge clk_i);
    #1;
    acc_base = acc_cnt; cur_size = 4;
    exp_aw.push_back(32'h6000_0000);
    exp_w.push_back(32'hA5A5_0001);
    start_i = 1'b1; base_addr_i = 32'h6000_0000; size_i = 16'd4;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    data_valid_i = 1'b1;
    n = 0;
    while ((n < 50) && ((acc_cnt - acc_base) < 2)) begin
      data_i = 32'hA5A5_0001 + 32'(acc_cnt - acc_base);
      @(posedge clk_i);
      #1;
      n++;
    end
    data_valid_i = 1'b0;
    check("rst_setup_accepted", 32'(acc_cnt - acc_base), 32'd2);
    n = 0;
    while ((n < 50) && !awvalid_o) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    check("rst_setup_awvalid", 32'(awvalid_o), 32'd1);
    @(negedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    check("async_rst_awvalid", 32'(awvalid_o), 32'd0);
    check("async_rst_wvalid", 32'(wvalid_o), 32'd0);
    check("async_rst_busy", 32'(busy_o), 32'd0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    aw_prob = 100; w_prob = 100;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_no_done", 32'(done_cnt), 32'd0);
    check("rst_fifo_empty", 32'(awvalid_o), 32'd0);
    run_transfer(32'h7000_0000, 3, 100, 1'b0, 1'b0, 1'b0);

`ifdef CGRA_OUT_BRESP_ERR_EN
    err_idx = 1;
    run_transfer(32'h8000_0000, 3, 100, 1'b0, 1'b0, 1'b0);
    check("err_set", 32'(err_o), 32'd1);
    check("err_one", 32'(err_count_o), 32'd1);
    err_idx = -1;
    run_transfer(32'h8000_1000, 2, 100, 1'b0, 1'b0, 1'b0);
    check("err_cleared", 32'(err_o), 32'd0);
    check("err_cnt_cleared", 32'(err_count_o), 32'd0);
    err_idx = -2;
    run_transfer(32'h8000_2000, 260, 100, 1'b0, 1'b0, 1'b0);
    check("err_saturated", 32'(err_count_o), 32'd255);
    err_idx = -1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
